// File: rtl/spi_wb_controller_if.sv
// spi_wb_controller_if: SPI word-side and Wishbone-side signals of spi_wb_controller
interface spi_wb_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [31:0]       wb_dat_o;
  logic [31:0]       wb_dat_i;
  logic              wb_we_o;
  logic [3:0]        wb_sel_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_ack_i;
  logic              busy;
  logic              err;
  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    output rx_ready, tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o,
           wb_cyc_o, wb_stb_o, busy, err
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    input  rx_ready, tx_data, tx_valid, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o,
           wb_cyc_o, wb_stb_o, busy, err
  );
endinterface

// File: rtl/spi_wb_controller.sv
// spi_wb_controller: SPI byte commands to single 32-bit Wishbone cycles, read data queued to SPI TX.
// Define SPIWB_ACK_TIMEOUT_EN to abort Wishbone cycles that get no ack within ACK_TO clocks.
module spi_wb_controller #(
  parameter int ADDR_W  = 16,
  parameter int BYTE_TO = 270000,
  parameter int ACK_TO  = 255
) (
  input logic      clk,
  input logic      rst,
  spi_wb_if.master bus
);
  localparam int NB = ADDR_W / 8;
  localparam int TW = $clog2(BYTE_TO + 1);
  typedef enum logic [1:0] {IDLE, ADDR, WDATA, WB} state_t;
  state_t            state, state_n;
  logic [3:0]        bcnt;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] adr;
  logic [31:0]       dat, q, q_n;
  logic [2:0]        cnt, cnt_n;
  logic [7:0]        tx_data;
  logic              we, err, tx_ready_q, byte_to, ack_to, done, rd_ack, pop, err_set, err_clr;
  assign byte_to = (state == ADDR || state == WDATA) && !bus.rx_valid && tcnt == TW'(BYTE_TO - 1);
  assign done    = state == WB && (bus.wb_ack_i || ack_to);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.rx_valid && (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) ? ADDR : IDLE;
      ADDR:    state_n = bus.rx_valid && bcnt == 4'(NB - 1) ? (we ? WDATA : WB) : byte_to ? IDLE : ADDR;
      WDATA:   state_n = bus.rx_valid && bcnt == 4'd3 ? WB : byte_to ? IDLE : WDATA;
      default: state_n = done ? IDLE : WB;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
`ifdef SPIWB_ACK_TIMEOUT_EN
  localparam int AW = $clog2(ACK_TO + 1);
  logic [AW-1:0] acnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) acnt <= '0;
    else acnt <= state == WB && !bus.wb_ack_i ? acnt + AW'(1) : '0;
  assign ack_to = state == WB && !bus.wb_ack_i && acnt == AW'(ACK_TO - 1);
`else
  // never fires; the ack-wait is unbounded in this build
  assign ack_to = 1'b0 && ACK_TO != 0;
`endif
  assign err_set = byte_to || ack_to || (state == WB && bus.rx_valid);
  assign err_clr = state == IDLE && bus.rx_valid && bus.rx_data == 8'h03;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bcnt <= '0;
      tcnt <= '0;
      adr  <= '0;
      dat  <= '0;
      we   <= 1'b0;
      err  <= 1'b0;
    end else begin
      bcnt <= state_n != state || state == IDLE ? '0 : bcnt + {3'b000, bus.rx_valid};
      tcnt <= bus.rx_valid || !(state == ADDR || state == WDATA) ? '0 : tcnt + TW'(1);
      we   <= state == IDLE && bus.rx_valid ? bus.rx_data == 8'h01 : done ? 1'b0 : we;
      if (state == ADDR && bus.rx_valid) adr <= ADDR_W'({adr, bus.rx_data});
      if (state == WDATA && bus.rx_valid) dat <= {dat[23:0], bus.rx_data};
      err  <= err_set ? 1'b1 : err_clr ? 1'b0 : err;
    end
  // a read completion overrides a simultaneous pop and any undrained bytes
  assign rd_ack = done && !we;
  assign pop    = tx_ready_q && !bus.tx_ready && cnt != 3'd0;
  assign q_n    = rd_ack ? (bus.wb_ack_i ? bus.wb_dat_i : 32'hDEADBEEF) : pop ? {q[23:0], 8'h00} : q;
  assign cnt_n  = rd_ack ? 3'd4 : pop ? cnt - 3'd1 : cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q          <= '0;
      cnt        <= '0;
      tx_data    <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      q          <= q_n;
      cnt        <= cnt_n;
      tx_ready_q <= bus.tx_ready;
      if (!bus.tx_ready) tx_data <= cnt_n != 3'd0 ? q_n[31:24] : {state != IDLE, err, 3'b000, cnt_n};
    end
  assign bus.rx_ready = state != WB;
  assign bus.tx_data  = tx_data;
  assign bus.tx_valid = 1'b1;
  assign bus.wb_adr_o = adr;
  assign bus.wb_dat_o = dat;
  assign bus.wb_we_o  = we;
  assign bus.wb_cyc_o = state == WB;
  assign bus.wb_stb_o = state == WB;
  assign bus.wb_sel_o = {4{state == WB}};
  assign bus.busy     = state != IDLE;
  assign bus.err      = err;
endmodule

// File: tb/tb_spi_wb_controller.sv
// tb_spi_wb_controller: directed vector table plus hand-written corner sequences for spi_wb_controller.
module tb_spi_wb_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  spi_wb_if #(.ADDR_W(16)) bus ();
  spi_wb_controller #(.ADDR_W(16), .BYTE_TO(40), .ACK_TO(30)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] adr;
    logic [31:0] dat;
    logic        exp_cyc;
    logic        exp_we;
    logic [31:0] exp_tx;
  } vec_t;
  vec_t v [6];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic wait_cyc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++)
      if (bus.wb_cyc_o) ok = 1'b1;
      else @(negedge clk);
  endtask
  task automatic ack(input logic [31:0] d);
    bus.wb_dat_i = d;
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
  endtask
  task automatic load(output logic [7:0] b);
    @(negedge clk);
    b = bus.tx_data;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
  initial begin
    bit ok, seen;
    logic [7:0] b;
    v[0] = '{8'h01, 16'h1234, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0};
    v[1] = '{8'h02, 16'h0010, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D};
    v[2] = '{8'h55, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h0};
    v[3] = '{8'h01, 16'hABCD, 32'h01020304, 1'b1, 1'b1, 32'h0};
    v[4] = '{8'h02, 16'hFFFF, 32'h80000001, 1'b1, 1'b0, 32'h80000001};
    v[5] = '{8'h00, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h0};
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    bus.wb_dat_i = 32'h0;
    bus.wb_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h1);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'h1);
    check("rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
    check("rst_stb", 32'(bus.wb_stb_o), 32'h0);
    check("rst_sel", 32'(bus.wb_sel_o), 32'h0);
    check("rst_adr", 32'(bus.wb_adr_o), 32'h0);
    check("rst_dat", bus.wb_dat_o, 32'h0);
    check("rst_we", 32'(bus.wb_we_o), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send(v[i].cmd);
      if (v[i].exp_cyc) begin
        send(v[i].adr[15:8]);
        send(v[i].adr[7:0]);
        if (v[i].exp_we) for (int k = 3; k >= 0; k--) send(v[i].dat[8*k +: 8]);
        wait_cyc(ok);
        check("cyc_start", 32'(ok), 32'h1);
        check("adr", 32'(bus.wb_adr_o), 32'(v[i].adr));
        check("we", 32'(bus.wb_we_o), 32'(v[i].exp_we));
        check("sel", 32'(bus.wb_sel_o), 32'hF);
        check("stb", 32'(bus.wb_stb_o), 32'h1);
        check("busy_wb", 32'(bus.busy), 32'h1);
        if (v[i].exp_we) check("wdat", bus.wb_dat_o, v[i].dat);
        ack(v[i].exp_we ? 32'h0 : v[i].dat);
        check("cyc_end", 32'(bus.wb_cyc_o), 32'h0);
        check("busy_end", 32'(bus.busy), 32'h0);
        if (!v[i].exp_we)
          for (int k = 0; k < 4; k++) begin
            load(b);
            check("tx_byte", 32'(b), 32'(v[i].exp_tx[31-8*k -: 8]));
          end
        @(negedge clk);
        check("status", 32'(bus.tx_data), 32'h00);
      end else begin
        seen = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (bus.wb_cyc_o || bus.busy) seen = 1'b1;
        end
        check("nop_idle", 32'(seen), 32'h0);
      end
    end
    // byte timeout inside a write command
    send(8'h01);
    send(8'h12);
    check("to_busy_mid", 32'(bus.busy), 32'h1);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.wb_cyc_o) seen = 1'b1;
    end
    check("to_nocyc", 32'(seen), 32'h0);
    check("to_err", 32'(bus.err), 32'h1);
    check("to_busy", 32'(bus.busy), 32'h0);
    check("to_status", 32'(bus.tx_data), 32'h40);
    send(8'h03);
    @(negedge clk);
    check("clr_err", 32'(bus.err), 32'h0);
    check("clr_status", 32'(bus.tx_data), 32'h00);
    // overrun: byte arriving during the Wishbone cycle
    send(8'h02);
    send(8'h00);
    send(8'h20);
    wait_cyc(ok);
    check("ovr_cyc", 32'(ok), 32'h1);
    check("ovr_rx_ready", 32'(bus.rx_ready), 32'h0);
    send(8'h77);
    check("ovr_still_cyc", 32'(bus.wb_cyc_o), 32'h1);
    check("ovr_adr", 32'(bus.wb_adr_o), 32'h0020);
    ack(32'h11223344);
    check("ovr_busy", 32'(bus.busy), 32'h0);
    check("ovr_err", 32'(bus.err), 32'h1);
    load(b);
    check("ovr_tx0", 32'(b), 32'h11);
    send(8'h03);
    check("ovr_clr", 32'(bus.err), 32'h0);
    // new read overwrites undrained bytes
    send(8'h02);
    send(8'h00);
    send(8'h30);
    wait_cyc(ok);
    check("ow_cyc", 32'(ok), 32'h1);
    ack(32'hAABBCCDD);
    load(b);
    check("ow_tx0", 32'(b), 32'hAA);
`ifdef SPIWB_ACK_TIMEOUT_EN
    send(8'h02);
    send(8'h00);
    send(8'h50);
    wait_cyc(ok);
    check("ato_cyc", 32'(ok), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (!bus.wb_cyc_o) seen = 1'b1;
    end
    check("ato_abort", 32'(seen), 32'h1);
    check("ato_err", 32'(bus.err), 32'h1);
    check("ato_busy", 32'(bus.busy), 32'h0);
    load(b);
    check("ato_tx0", 32'(b), 32'hDE);
    load(b);
    check("ato_tx1", 32'(b), 32'hAD);
    load(b);
    check("ato_tx2", 32'(b), 32'hBE);
    load(b);
    check("ato_tx3", 32'(b), 32'hEF);
    @(negedge clk);
    check("ato_status", 32'(bus.tx_data), 32'h40);
    send(8'h03);
`endif
    // reset in the middle of a Wishbone read
    send(8'h02);
    send(8'h00);
    send(8'h40);
    wait_cyc(ok);
    check("mrst_cyc", 32'(ok), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mrst_cyc_drop", 32'(bus.wb_cyc_o), 32'h0);
    check("mrst_stb_drop", 32'(bus.wb_stb_o), 32'h0);
    check("mrst_tx_data", 32'(bus.tx_data), 32'h00);
    check("mrst_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_status", 32'(bus.tx_data), 32'h00);
    check("mrst_rx_ready", 32'(bus.rx_ready), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
